// File: rtl/decim_ctrl_if.sv
// Output stream of the decimation controller: FIFO head plus valid/ready.
interface decim_ctrl_if #(
    parameter int DW = 10
);
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/decim_ctrl.sv
// Receive-path decimator sequencer: captures one din word every N cycles
// into a small FWFT FIFO, with run/drain sequencing and ratio hand-over.
module decim_ctrl #(
    parameter int DW            = 10,
    parameter int RW            = 8,
    parameter int DEPTH         = 4,
    parameter int DEFAULT_RATIO = 11
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   cfg_wr,
    input  logic [RW-1:0]          cfg_ratio,
    output logic                   cfg_ack,
    output logic                   cfg_err,
    input  logic [DW-1:0]          din,
    decim_ctrl_if.master           strm,
    output logic                   sample_stb,
    output logic                   busy,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_d;
    logic [RW-1:0]   count, count_d;
    logic [RW-1:0]   n_act, pending;
    logic            pend_v;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wp, rp, rp_d;
    logic [LW-1:0]   level_d;
    logic            capture, apply, pop, push, full;

    always_comb begin
        state_d = state;
        count_d = count;
        capture = 1'b0;
        apply   = 1'b0;
        unique case (state)
            IDLE: begin
                count_d = '0;
                apply   = pend_v;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_d = DRAIN;
                end else if (count == n_act - RW'(1)) begin
                    capture = 1'b1;
                    count_d = '0;
                    apply   = pend_v;
                end else begin
                    count_d = count + RW'(1);
                end
            end
            DRAIN: begin
                count_d = '0;
                apply   = pend_v;
                if (level == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A capture into a full FIFO still lands if the head leaves this edge.
    assign pop     = strm.dout_valid && strm.dout_ready;
    assign full    = (level == LW'(DEPTH));
    assign push    = capture && (!full || pop);
    assign level_d = level + LW'(push) - LW'(pop);
    assign rp_d    = rp + AW'(pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            count           <= '0;
            n_act           <= RW'(DEFAULT_RATIO);
            pending         <= '0;
            pend_v          <= 1'b0;
            cfg_ack         <= 1'b0;
            cfg_err         <= 1'b0;
            sample_stb      <= 1'b0;
            busy            <= 1'b0;
            ovf             <= 1'b0;
            wp              <= '0;
            rp              <= '0;
            level           <= '0;
            strm.dout       <= '0;
            strm.dout_valid <= 1'b0;
        end else begin
            state      <= state_d;
            count      <= count_d;
            cfg_ack    <= apply;
            cfg_err    <= cfg_wr && (cfg_ratio == '0);
            sample_stb <= capture;
            busy       <= (state_d != IDLE);
            if (apply) n_act <= pending;
            // A write on the apply edge becomes the next pending value.
            if (cfg_wr && (cfg_ratio != '0)) begin
                pending <= cfg_ratio;
                pend_v  <= 1'b1;
            end else if (apply) begin
                pend_v  <= 1'b0;
            end
            if (state == IDLE && state_d == RUN) ovf <= 1'b0;
            else if (capture && !push)           ovf <= 1'b1;
            if (push) wp <= wp + AW'(1);
            rp              <= rp_d;
            level           <= level_d;
            strm.dout_valid <= (level_d != '0);
            if (push || (pop && level_d != '0))
                strm.dout <= (push && wp == rp_d) ? din : mem[rp_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
endmodule

// File: tb/tb_decim_ctrl.sv
// Directed bench for decim_ctrl: ratio timing, ratio changes, FIFO fill,
// overflow, drain sequencing and asynchronous reset.
module tb_decim_ctrl;
    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       cfg_wr;
    logic [7:0] cfg_ratio;
    logic       cfg_ack;
    logic       cfg_err;
    logic [9:0] din;
    logic       sample_stb;
    logic       busy;
    logic       ovf;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    decim_ctrl_if #(.DW(10)) strm ();

    decim_ctrl #(
        .DW(10), .RW(8), .DEPTH(4), .DEFAULT_RATIO(11)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .cfg_wr     (cfg_wr),
        .cfg_ratio  (cfg_ratio),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .din        (din),
        .strm       (strm),
        .sample_stb (sample_stb),
        .busy       (busy),
        .ovf        (ovf),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // din after edge k equals k, so a capture on edge k stores k-1
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        din = 10'(cyc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, 32'(cfg_ack), 0);
        chk({tag, "_err"}, 32'(cfg_err), 0);
        chk({tag, "_dout"}, 32'(strm.dout), 0);
        chk({tag, "_valid"}, 32'(strm.dout_valid), 0);
        chk({tag, "_stb"}, 32'(sample_stb), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ovf"}, 32'(ovf), 0);
        chk({tag, "_level"}, 32'(level), 0);
    endtask

    initial begin
        rstn = 1'b0;
        en = 1'b0;
        cfg_wr = 1'b0;
        cfg_ratio = '0;
        din = '0;
        strm.dout_ready = 1'b0;
        #12;
        chk_reset_outputs("rst");
        rstn = 1'b1;
        en = 1'b1;
        strm.dout_ready = 1'b1;

        // Edge 0: IDLE -> RUN at the default ratio of 11
        step();
        cyc = 0;
        din = '0;
        chk("busy_rise", 32'(busy), 1);
        for (int k = 1; k <= 33; k++) begin
            step();
            chk($sformatf("a_stb%0d", k), 32'(sample_stb),
                32'((k % 11) == 0));
            if ((k % 11) == 0) begin
                chk($sformatf("a_dout%0d", k), 32'(strm.dout), k - 1);
                chk($sformatf("a_ovf%0d", k), 32'(ovf), 0);
            end
        end

        // Ratio 3 written mid-period; then a rejected ratio 0
        for (int k = 34; k <= 56; k++) begin
            step();
            if (k == 38) begin cfg_wr = 1'b1; cfg_ratio = 8'd3; end
            if (k == 39) cfg_wr = 1'b0;
            if (k == 50) begin cfg_wr = 1'b1; cfg_ratio = 8'd0; end
            if (k == 51) cfg_wr = 1'b0;
            chk($sformatf("b_stb%0d", k), 32'(sample_stb),
                32'(k == 44 || (k > 44 && ((k - 44) % 3) == 0)));
            chk($sformatf("b_ack%0d", k), 32'(cfg_ack), 32'(k == 44));
            chk($sformatf("b_err%0d", k), 32'(cfg_err), 32'(k == 51));
            if (sample_stb)
                chk($sformatf("b_dout%0d", k), 32'(strm.dout), k - 1);
        end

        // Ratio 1 with the sink stalled: fill, then overflow
        cfg_wr = 1'b1;
        cfg_ratio = 8'd1;
        step();
        cfg_wr = 1'b0;
        strm.dout_ready = 1'b0;
        chk("c_level57", 32'(level), 0);
        for (int k = 58; k <= 64; k++) begin
            step();
            chk($sformatf("c_level%0d", k), 32'(level),
                (k < 59) ? 0 : ((k > 62) ? 4 : k - 58));
            chk($sformatf("c_ovf%0d", k), 32'(ovf), 32'(k >= 63));
            if (k == 59) chk("c_ack59", 32'(cfg_ack), 1);
            if (k >= 59)
                chk($sformatf("c_dout%0d", k), 32'(strm.dout), 58);
        end

        // Sink released: push and pop together, level pinned at 4
        strm.dout_ready = 1'b1;
        for (int k = 65; k <= 72; k++) begin
            step();
            chk($sformatf("d_level%0d", k), 32'(level), 4);
            chk($sformatf("d_ovf%0d", k), 32'(ovf), 1);
            chk($sformatf("d_dout%0d", k), 32'(strm.dout),
                (k < 68) ? k - 6 : k - 4);
        end

        // Stop: one pop leaves 3 words, then drain with a stall
        en = 1'b0;
        step();
        strm.dout_ready = 1'b0;
        chk("e_level73", 32'(level), 3);
        chk("e_dout73", 32'(strm.dout), 69);
        for (int k = 74; k <= 79; k++) begin
            step();
            if (k == 75) strm.dout_ready = 1'b1;
            chk($sformatf("e_stb%0d", k), 32'(sample_stb), 0);
            chk($sformatf("e_busy%0d", k), 32'(busy), 32'(k < 79));
            chk($sformatf("e_level%0d", k), 32'(level),
                (k <= 75) ? 3 : ((k >= 78) ? 0 : 78 - k));
            chk($sformatf("e_valid%0d", k), 32'(strm.dout_valid),
                32'(k < 78));
            if (k >= 76 && k <= 77)
                chk($sformatf("e_dout%0d", k), 32'(strm.dout), k - 6);
        end

        // Restart clears the sticky overflow
        en = 1'b1;
        step();
        strm.dout_ready = 1'b0;
        chk("f_ovf", 32'(ovf), 0);
        chk("f_busy", 32'(busy), 1);
        step();
        step();
        step();
        chk("f_level", 32'(level), 3);
        chk("f_dout", 32'(strm.dout), 80);

        // Asynchronous reset mid-run with data buffered
        rstn = 1'b0;
        #1;
        chk_reset_outputs("arst");
        rstn = 1'b1;
        strm.dout_ready = 1'b1;
        step();
        cyc = 0;
        din = '0;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk($sformatf("g_stb%0d", k), 32'(sample_stb), 32'(k == 11));
        end
        chk("g_dout", 32'(strm.dout), 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
